data_memory_be: RTL and testbench

DATA_MEMORY_BE -- requirements
Module: data_memory_be

---
 rtl/common.sv | 21 ++
 rtl/mem_lane_align.sv | 41 ++++
 rtl/data_memory_be.sv | 182 ++++++++++++++++++
 tb/tb_data_memory_be.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/common.sv
// Shared types and constants for the data memory block.
package common;

    // Access size encoding carried on req_size.
    typedef enum logic [1:0] {
        SIZE_BYTE   = 2'b00,
        SIZE_HALF   = 2'b01,
        SIZE_WORD   = 2'b10,
        SIZE_DOUBLE = 2'b11
    } mem_size_t;

    // Controller states: sweep memory to zero, then serve requests.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } mem_state_t;

    // Level of rst that resets the block.
    localparam logic RESET = 1'b1;

endpackage

// File: rtl/mem_lane_align.sv
// Load data alignment: shifts the selected lanes of a memory word down to
// bit 0, masks to the access size and zero- or sign-extends the result.
module mem_lane_align
    import common::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]            word,
    input  logic [$clog2(DATA_WIDTH/8)-1:0]  lane_ofs,
    input  mem_size_t                        size,
    input  logic                             is_unsigned,
    output logic [DATA_WIDTH-1:0]            data
);

    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] mask;
    logic [DATA_WIDTH-1:0] sign_bit;
    logic                  sign;

    // Shift, mask and extend in one combinational pass.
    always_comb begin
        // NOTE: every combinational output gets a value on every path first,
        // otherwise synthesis infers a latch to hold the old value.
        mask    = '1;
        shifted = word >> {lane_ofs, 3'b000};
        case (size)
            SIZE_BYTE: mask = DATA_WIDTH'(8'hFF);
            SIZE_HALF: mask = DATA_WIDTH'(16'hFFFF);
            SIZE_WORD: mask = DATA_WIDTH'(32'hFFFF_FFFF);
            default:   mask = '1;
        endcase
        // Top bit of the mask marks the sign position of the access.
        sign_bit = mask & ~(mask >> 1);
        sign     = |(shifted & sign_bit);
        data     = shifted & mask;
        if (!is_unsigned && sign) begin
            data = data | ~mask;
        end
    end

endmodule

// File: rtl/data_memory_be.sv
// Byte-enabled data memory with a power-up clear sweep, one-cycle load
// latency and fault reporting for misaligned or illegal-size accesses.
module data_memory_be
    import common::*;
#(
    parameter int ADDRESS_WIDTH = 6,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          req_valid,
    output logic                                          req_ready,
    input  logic                                          req_write,
    input  mem_size_t                                     req_size,
    input  logic                                          req_unsigned,
    input  logic [ADDRESS_WIDTH+$clog2(DATA_WIDTH/8)-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]                         req_wdata,
    output logic                                          rsp_valid,
    output logic [DATA_WIDTH-1:0]                         rsp_rdata,
    output logic                                          rsp_fault
);

    localparam int LANES        = DATA_WIDTH / 8;
    localparam int OFS          = $clog2(LANES);
    localparam int MEMORY_DEPTH = 1 << ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] LAST_WORD = ADDRESS_WIDTH'(MEMORY_DEPTH - 1);

    mem_state_t state, state_next;
    logic [ADDRESS_WIDTH-1:0] clr_cnt;

    logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

    logic [ADDRESS_WIDTH-1:0] word_addr;
    logic [OFS-1:0]           lane_ofs;
    logic [LANES-1:0]         size_lanes;
    logic                     req_fault;
    logic                     accept;
    logic                     store_en;

    logic [LANES-1:0]         wr_en;
    logic [ADDRESS_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]    wr_data;

    logic [DATA_WIDTH-1:0]    rd_word;
    logic                     rsp_load;
    mem_size_t                rsp_size;
    logic                     rsp_unsigned;
    logic [OFS-1:0]           rsp_ofs;
    logic [DATA_WIDTH-1:0]    aligned;

    assign word_addr = req_addr[ADDRESS_WIDTH+OFS-1:OFS];
    assign lane_ofs  = req_addr[OFS-1:0];
    assign accept    = req_valid && req_ready;
    assign store_en  = accept && req_write && !req_fault;

    // State register; reset restarts the clear sweep.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst == RESET) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // Next state: leave CLEAR once the last word has been zeroed.
    always_comb begin
        state_next = state;
        case (state)
            ST_CLEAR: if (clr_cnt == LAST_WORD) state_next = ST_READY;
            ST_READY: state_next = ST_READY;
            default:  state_next = ST_CLEAR;
        endcase
    end

    // Moore output: requests are taken only once the sweep is done.
    always_comb begin
        req_ready = (state == ST_READY);
    end

    // Clear counter walks every word once, wrapping back to 0 on exit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RESET) begin
            clr_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // Alignment check and lanes touched by the requested size.
    always_comb begin
        req_fault  = 1'b0;
        size_lanes = '1;
        case (req_size)
            SIZE_BYTE: begin
                size_lanes = LANES'(1);
            end
            SIZE_HALF: begin
                size_lanes = LANES'(3);
                req_fault  = req_addr[0];
            end
            SIZE_WORD: begin
                size_lanes = LANES'(15);
                req_fault  = |req_addr[1:0];
            end
            default: begin
                size_lanes = '1;
                req_fault  = (DATA_WIDTH != 64) || (|req_addr[2:0]);
            end
        endcase
    end

    // Single write port shared by the clear sweep and legal stores.
    always_comb begin
        wr_en   = '0;
        wr_addr = word_addr;
        wr_data = req_wdata << {lane_ofs, 3'b000};
        if (state == ST_CLEAR) begin
            wr_en   = '1;
            wr_addr = clr_cnt;
            wr_data = '0;
        end else if (store_en) begin
            wr_en = size_lanes << lane_ofs;
        end
    end

    // Byte-enabled memory write.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset so it maps onto block RAM; contents are
        // zeroed by the clear sweep instead.
        for (int i = 0; i < LANES; i++) begin
            if (wr_en[i]) begin
                mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
        end
    end

    // Registered read of the addressed word on every accepted request.
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_word <= mem[word_addr];
        end
    end

    // Response pipeline: one pulse per accepted request, dropped by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RESET) begin
            rsp_valid    <= 1'b0;
            rsp_fault    <= 1'b0;
            rsp_load     <= 1'b0;
            rsp_size     <= SIZE_BYTE;
            rsp_unsigned <= 1'b0;
            rsp_ofs      <= '0;
        end else begin
            rsp_valid <= accept;
            rsp_fault <= accept && req_fault;
            rsp_load  <= accept && !req_write && !req_fault;
            if (accept) begin
                rsp_size     <= req_size;
                rsp_unsigned <= req_unsigned;
                rsp_ofs      <= lane_ofs;
            end
        end
    end

    mem_lane_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lane_align (
        .word        (rd_word),
        .lane_ofs    (rsp_ofs),
        .size        (rsp_size),
        .is_unsigned (rsp_unsigned),
        .data        (aligned)
    );

    // Only legal loads return data; stores, faults and idle cycles read zero.
    always_comb begin
        rsp_rdata = rsp_load ? aligned : '0;
    end

endmodule

// File: tb/tb_data_memory_be.sv
// Directed bench for data_memory_be with hand-computed expected values.
module tb_data_memory_be;
    import common::*;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    mem_size_t   req_size;
    logic        req_unsigned;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    int checks = 0;
    int fails  = 0;
    int cnt;

    data_memory_be #(
        .ADDRESS_WIDTH (6),
        .DATA_WIDTH    (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_fault    (rsp_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic w, input mem_size_t sz, input logic u,
                           input logic [7:0] a, input logic [31:0] d);
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = d;
        req_valid    = 1'b1;
    endtask

    // Present one request for one edge (caller ensures req_ready is high).
    task automatic send(input logic w, input mem_size_t sz, input logic u,
                        input logic [7:0] a, input logic [31:0] d);
        set_req(w, sz, u, a, d);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic expect_rsp(input string tag, input logic fault, input logic [31:0] data);
        @(negedge clk);
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_fault"}, 32'(rsp_fault), 32'(fault));
        check({tag, "_rdata"}, rsp_rdata, data);
    endtask

    // Count low-ready samples until ready rises, bounded.
    task automatic wait_ready(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) break;
            n++;
        end
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = SIZE_BYTE;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_fault", 32'(rsp_fault), 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);

        // Release reset with a load already offered; it waits out the clear.
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_req(1'b0, SIZE_WORD, 1'b0, 8'h20, 32'd0);
        wait_ready(cnt);
        check("clear_cycles", cnt, 32'd64);
        check("no_rsp_during_clear", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        expect_rsp("load_0x20", 1'b0, 32'h0000_0000);

        // Byte loads with sign and zero extension.
        send(1'b1, SIZE_WORD, 1'b0, 8'h10, 32'h8081_8283);
        expect_rsp("store_0x10", 1'b0, 32'h0);
        send(1'b0, SIZE_BYTE, 1'b0, 8'h11, 32'h0);
        expect_rsp("lb_0x11", 1'b0, 32'hFFFF_FF82);
        send(1'b0, SIZE_BYTE, 1'b1, 8'h11, 32'h0);
        expect_rsp("lbu_0x11", 1'b0, 32'h0000_0082);

        // Half store into the upper half of a word.
        send(1'b1, SIZE_WORD, 1'b0, 8'h04, 32'h1122_3344);
        expect_rsp("store_0x04", 1'b0, 32'h0);
        send(1'b1, SIZE_HALF, 1'b0, 8'h06, 32'h0000_BEEF);
        expect_rsp("sh_0x06", 1'b0, 32'h0);
        send(1'b0, SIZE_WORD, 1'b0, 8'h04, 32'h0);
        expect_rsp("lw_0x04", 1'b0, 32'hBEEF_3344);

        // Faults leave memory untouched and return zero data.
        send(1'b1, SIZE_WORD, 1'b0, 8'h08, 32'hCAFE_F00D);
        expect_rsp("store_0x08", 1'b0, 32'h0);
        send(1'b0, SIZE_WORD, 1'b0, 8'h0A, 32'h0);
        expect_rsp("lw_mis_0x0A", 1'b1, 32'h0);
        send(1'b1, SIZE_WORD, 1'b0, 8'h0A, 32'hDEAD_BEEF);
        expect_rsp("sw_mis_0x0A", 1'b1, 32'h0);
        send(1'b1, SIZE_DOUBLE, 1'b0, 8'h08, 32'h1234_5678);
        expect_rsp("sd_illegal", 1'b1, 32'h0);
        send(1'b0, SIZE_HALF, 1'b0, 8'h0B, 32'h0);
        expect_rsp("lh_mis_0x0B", 1'b1, 32'h0);
        send(1'b0, SIZE_WORD, 1'b0, 8'h08, 32'h0);
        expect_rsp("lw_0x08", 1'b0, 32'hCAFE_F00D);

        // Half and byte lanes of the same word.
        send(1'b0, SIZE_HALF, 1'b1, 8'h0A, 32'h0);
        expect_rsp("lhu_0x0A", 1'b0, 32'h0000_CAFE);
        send(1'b0, SIZE_HALF, 1'b0, 8'h0A, 32'h0);
        expect_rsp("lh_0x0A", 1'b0, 32'hFFFF_CAFE);
        send(1'b0, SIZE_HALF, 1'b0, 8'h08, 32'h0);
        expect_rsp("lh_0x08", 1'b0, 32'hFFFF_F00D);
        send(1'b0, SIZE_BYTE, 1'b0, 8'h0B, 32'h0);
        expect_rsp("lb_0x0B", 1'b0, 32'hFFFF_FFCA);
        send(1'b1, SIZE_BYTE, 1'b0, 8'h09, 32'h0000_0055);
        expect_rsp("sb_0x09", 1'b0, 32'h0);
        send(1'b0, SIZE_WORD, 1'b0, 8'h08, 32'h0);
        expect_rsp("lw_0x08_sb", 1'b0, 32'hCAFE_550D);

        // Back-to-back store then load to the same word.
        set_req(1'b1, SIZE_WORD, 1'b0, 8'h30, 32'h1357_9BDF);
        @(posedge clk);
        #1;
        set_req(1'b0, SIZE_WORD, 1'b1, 8'h30, 32'h0);
        @(negedge clk);
        check("b2b_store_valid", 32'(rsp_valid), 32'd1);
        check("b2b_store_rdata", rsp_rdata, 32'h0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("b2b_load_valid", 32'(rsp_valid), 32'd1);
        check("b2b_load_rdata", rsp_rdata, 32'h1357_9BDF);
        @(negedge clk);
        check("b2b_idle_valid", 32'(rsp_valid), 32'd0);

        // Reset with a response pending drops it immediately.
        send(1'b0, SIZE_WORD, 1'b0, 8'h04, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_pend_valid", 32'(rsp_valid), 32'd0);
        check("rst_pend_rdata", rsp_rdata, 32'h0);
        check("rst_pend_ready", 32'(req_ready), 32'd0);

        // Reset at clear cycle 30 restarts the full sweep.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midclear_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_ready(cnt);
        check("reclear_cycles", cnt, 32'd64);

        // Sweep zeroed previously written words.
        send(1'b0, SIZE_WORD, 1'b0, 8'h30, 32'h0);
        expect_rsp("lw_0x30_cleared", 1'b0, 32'h0);
        send(1'b0, SIZE_WORD, 1'b0, 8'h04, 32'h0);
        expect_rsp("lw_0x04_cleared", 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
